// File: rtl/counter_timeoutpulse.sv
// Enable-gated timeout counter: counts cycles with 'in' high up to TIMEOUT,
// giving a level 'done' decode and a one-cycle registered 'done_pulse' on arrival.
module counter_timeoutpulse #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned TIMEOUT     = 5,
  parameter int unsigned AUTO_RELOAD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  output logic [WIDTH-1:0] counter,
  output logic             done,
  output logic             done_pulse
);

  localparam logic [WIDTH-1:0] TC       = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] TC_M1    = WIDTH'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam bit               RELOAD   = (AUTO_RELOAD != 0);

  logic [WIDTH-1:0] r_counter;
  logic             r_pulse;
  logic             w_at_tc;
  logic             w_arrive;
  logic [WIDTH-1:0] w_next;

  assign w_at_tc  = (r_counter == TC);
  assign w_arrive = in && (r_counter == TC_M1);

  // Next count: increment below terminal, then saturate or reload at terminal.
  always_comb begin
    w_next = r_counter;
    if (in) begin
      if (w_at_tc) begin
        w_next = RELOAD ? '0 : TC;
      end else begin
        w_next = r_counter + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_counter <= '0;
      r_pulse   <= 1'b0;
    end else begin
      r_counter <= w_next;
      r_pulse   <= w_arrive;
    end
  end

  assign counter    = r_counter;
  assign done       = w_at_tc;
  assign done_pulse = r_pulse;

`ifdef SIM
  logic r_prev_pulse;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev_pulse <= 1'b0;
    end else begin
      r_prev_pulse <= r_pulse;
    end
  end

  // Pulse must be a single cycle and always coincide with the done level.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(r_prev_pulse && r_pulse));
      assert (!r_pulse || done);
      assert (r_counter <= TC);
    end
  end
`endif

endmodule

// File: tb/tb_counter_timeoutpulse.sv
// Randomised and directed bench for counter_timeoutpulse across saturating,
// auto-reload and TIMEOUT=1 configurations against an arithmetic reference model.
module tb_counter_timeoutpulse;

  localparam int unsigned N = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in  = 1'b0;
  logic [3:0] cnt [N];
  logic       dn  [N];
  logic       dp  [N];

  int unsigned tmo [N] = '{5, 5, 1};
  bit          rld [N] = '{1'b0, 1'b1, 1'b0};
  int unsigned m_c [N];
  bit          m_p [N];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  counter_timeoutpulse #(.WIDTH(4), .TIMEOUT(5), .AUTO_RELOAD(0)) u_sat (
    .clk(clk), .rst(rst), .in(in), .counter(cnt[0]), .done(dn[0]), .done_pulse(dp[0]));
  counter_timeoutpulse #(.WIDTH(4), .TIMEOUT(5), .AUTO_RELOAD(1)) u_rld (
    .clk(clk), .rst(rst), .in(in), .counter(cnt[1]), .done(dn[1]), .done_pulse(dp[1]));
  counter_timeoutpulse #(.WIDTH(4), .TIMEOUT(1), .AUTO_RELOAD(0)) u_one (
    .clk(clk), .rst(rst), .in(in), .counter(cnt[2]), .done(dn[2]), .done_pulse(dp[2]));

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_c[i] = 0;
      m_p[i] = 1'b0;
    end
  endtask

  // One enabled/disabled clock step of the reference: pulse on arrival at TIMEOUT.
  task automatic model_step(input bit en);
    for (int i = 0; i < N; i++) begin
      m_p[i] = en && (m_c[i] + 1 == tmo[i]);
      if (en) begin
        if (m_c[i] == tmo[i]) m_c[i] = rld[i] ? 0 : tmo[i];
        else                  m_c[i] = m_c[i] + 1;
      end
    end
  endtask

  task automatic check(input string tag);
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      assert (cnt[i] === 4'(m_c[i])) else begin
        n_err++;
        $error("FAIL %s.counter[%0d] observed=%0d expected=%0d", tag, i, cnt[i], m_c[i]);
      end
      n_cmp++;
      assert (dn[i] === (m_c[i] == tmo[i])) else begin
        n_err++;
        $error("FAIL %s.done[%0d] observed=%b expected=%b", tag, i, dn[i], m_c[i] == tmo[i]);
      end
      n_cmp++;
      assert (dp[i] === m_p[i]) else begin
        n_err++;
        $error("FAIL %s.done_pulse[%0d] observed=%b expected=%b", tag, i, dp[i], m_p[i]);
      end
    end
  endtask

  task automatic tick(input bit en, input string tag);
    in = en;
    @(posedge clk);
    model_step(en);
    #1;
    check(tag);
  endtask

  // Synchronous-looking reset held across two edges, released away from an edge.
  task automatic sync_reset(input string tag);
    rst = 1'b0;
    in  = 1'b1;
    model_reset();
    #1;
    check({tag, "_async"});
    repeat (2) begin
      @(posedge clk);
      #1;
      check({tag, "_hold"});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Reset asserted between edges must clear outputs without a clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);

    // Reset with enable high: counters stay cleared, then first enabled edge counts.
    sync_reset("rst");
    tick(1'b1, "first_count");

    // Consecutive enables to terminal, then hold/reload behaviour.
    repeat (4) tick(1'b1, "run_to_tc");
    tick(1'b1, "past_tc");

    // Asynchronous reset while done, then recount so the pulse fires again.
    async_reset("async_in_done");
    repeat (6) tick(1'b1, "recount");

    // Alternating enable pattern accumulates across gaps.
    sync_reset("rst_alt");
    for (int k = 0; k < 9; k++) tick(((k % 2) == 0), "alternate");

    // Long enable run exercises reload twice in the auto-reload instance.
    sync_reset("rst_reload");
    repeat (12) tick(1'b1, "reload_run");

    // Idle gap holds the count below terminal.
    sync_reset("rst_idle");
    repeat (3) tick(1'b1, "to_three");
    repeat (10) tick(1'b0, "idle_hold");

    // Random enables with occasional mid-cycle resets.
    for (int k = 0; k < 300; k++) begin
      tick(1'($urandom_range(0, 99) < 65), "random");
      if ($urandom_range(0, 39) == 0) async_reset("random_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
